// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared state encoding and default sizes for the run-control block
package cpu_run_ctrl_pkg;

  // Run-control states; the numeric values are visible on state_o
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HALT = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4
  } run_state_t;

  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_DATA_W       = 9;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_STEP_TIMEOUT = 32;

  // Completed-instruction counter width and its saturation value
  localparam int INSTR_CNT_W = 8;
  localparam logic [INSTR_CNT_W-1:0] INSTR_CNT_MAX = '1;

endpackage

// File: rtl/cpu_load_port.sv
// rtl/cpu_load_port.sv - host write handshake, address range check and SRAM write registers
module cpu_load_port
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready_next,
  input  logic              clear_err,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_err
);

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic accept;
  logic in_range;

  assign accept   = host_valid & host_ready;
  assign in_range = ({1'b0, host_addr} < DEPTH_L);

  // Capture accepted beats; out-of-range beats are swallowed and flagged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_err   <= 1'b0;
    end else begin
      host_ready <= ready_next;
      mem_we     <= accept & in_range;
      if (accept && in_range) begin
        mem_addr  <= host_addr;
        mem_wdata <= host_data;
      end
      if (clear_err) begin
        load_err <= 1'b0;
      end else if (accept && !in_range) begin
        load_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - program-load and run/step/halt sequencer for the microprogrammed CPU
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STEP_TIMEOUT = DEF_STEP_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_data,
  input  logic                   host_load_done,
  input  logic                   cmd_run,
  input  logic                   cmd_step,
  input  logic                   cmd_halt,
  input  logic                   instr_done,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   cpu_rst,
  output logic                   cpu_clk_en,
  output logic [2:0]             state_o,
  output logic                   load_err,
  output logic                   step_timeout,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  localparam int TMO_W = $clog2(STEP_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(STEP_TIMEOUT - 1);

  run_state_t       state_q, state_d;
  logic             halt_pend_q, halt_pend_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             step_to_q, step_to_d;
  logic             cpu_rst_d, cpu_clk_en_d, ready_d;
  logic             load_entry;

  assign load_entry   = (state_d == ST_LOAD) && (state_q != ST_LOAD);
  assign state_o      = state_q;
  assign step_timeout = step_to_q;

  // State, run-control bookkeeping and registered CPU control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      halt_pend_q <= 1'b0;
      tmo_cnt_q   <= '0;
      step_to_q   <= 1'b0;
      cpu_rst     <= 1'b1;
      cpu_clk_en  <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      tmo_cnt_q   <= tmo_cnt_d;
      step_to_q   <= step_to_d;
      cpu_rst     <= cpu_rst_d;
      cpu_clk_en  <= cpu_clk_en_d;
    end
  end

  // Next-state: halt beats step beats run; the host only gets in while the CPU is stopped
  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    tmo_cnt_d   = tmo_cnt_q;
    step_to_d   = step_to_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (cmd_step) begin
          state_d = ST_STEP;
        end else if (cmd_run) begin
          state_d = ST_RUN;
        end else if (host_valid) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (host_load_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A halt request waits for the next instruction boundary
        if (instr_done && halt_pend_q) begin
          state_d = ST_HALT;
        end else if (cmd_halt) begin
          halt_pend_d = 1'b1;
        end
      end
      ST_STEP: begin
        // instr_done on the last allowed cycle still counts as a clean step
        if (instr_done) begin
          state_d = ST_HALT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_HALT;
          step_to_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != ST_RUN) begin
      halt_pend_d = 1'b0;
    end
    if ((state_d == ST_STEP) && (state_q != ST_STEP)) begin
      tmo_cnt_d = '0;
    end
    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      step_to_d = 1'b0;
    end
  end

  // Output decode from the next state so the registered outputs line up with state_o
  always_comb begin
    cpu_rst_d    = 1'b1;
    cpu_clk_en_d = 1'b0;
    ready_d      = 1'b0;
    unique case (state_d)
      ST_LOAD: ready_d = 1'b1;
      ST_RUN, ST_STEP: begin
        cpu_rst_d    = 1'b0;
        cpu_clk_en_d = 1'b1;
      end
      ST_HALT: cpu_rst_d = 1'b0;
      default: begin
        cpu_rst_d    = 1'b1;
        cpu_clk_en_d = 1'b0;
      end
    endcase
  end

  // Completed-instruction counter; a finished load session starts a fresh count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= '0;
    end else if ((state_q == ST_LOAD) && host_load_done) begin
      instr_count <= '0;
    end else if (instr_done && cpu_clk_en && (instr_count != INSTR_CNT_MAX)) begin
      instr_count <= instr_count + 1'b1;
    end
  end

  cpu_load_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_load_port (
    .clk        (clk),
    .rst        (rst),
    .ready_next (ready_d),
    .clear_err  (load_entry),
    .host_valid (host_valid),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .host_ready (host_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .load_err   (load_err)
  );

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control and program-load controller for the microprogrammed CPU. It shares the instruction/data SRAM between an external host loader and the CPU, holding the CPU in reset while the program is written. It then sequences execution as free run, single macro-instruction step, or halt at an instruction boundary, using the microcode CLR pulse as the end-of-instruction marker.

## Interface
- ADDR_W, 5, SRAM address width
- DATA_W, 9, SRAM word width
- DEPTH, 16, number of writable SRAM locations; addresses ≥ DEPTH are rejected
- STEP_TIMEOUT, 32, maximum cycles a STEP may run without an end-of-instruction pulse
- clk  in  1  system clock, single domain
- rst  in  1  asynchronous, active-low reset
- host_valid  in  1  host write request
- host_ready  out  1  controller accepts a host word this cycle
- host_addr  in  ADDR_W  host write address
- host_data  in  DATA_W  host write data
- host_load_done  in  1  one-cycle pulse that ends a load session
- cmd_run / cmd_step / cmd_halt  in  1 each  one-cycle command pulses
- instr_done  in  1  CPU microcode CLR (end of macro-instruction)
- mem_we  out  1  SRAM write strobe, active-high
- mem_addr  out  ADDR_W  SRAM write address
- mem_wdata  out  DATA_W  SRAM write data
- cpu_rst  out  1  active-high reset to CPU core
- cpu_clk_en  out  1  CPU clock enable
- state_o  out  3  current state encoding
- load_err  out  1  sticky out-of-range write flag
- step_timeout  out  1  sticky step-timeout flag
- instr_count  out  8  completed macro-instructions, saturating

## Operation
- States: IDLE=0, LOAD=1, HALT=2, RUN=3, STEP=4.
- IDLE: cpu_rst=1, cpu_clk_en=0.
  - host_valid → LOAD.
  - cmd_step → STEP.
  - cmd_run → RUN.
- LOAD: cpu_rst=1, cpu_clk_en=0, host_ready=1. Every host_valid&host_ready beat is accepted.
  - addr < DEPTH: mem_we pulses with the captured addr/data.
  - addr ≥ DEPTH: no write; load_err is set.
  - host_load_done → IDLE and clears instr_count. If a valid beat arrives in the same cycle, that beat is still accepted.
- RUN: cpu_rst=0, cpu_clk_en=1.
  - cmd_halt sets halt_pending.
  - instr_done with halt_pending → HALT and clears halt_pending.
- STEP: cpu_rst=0, cpu_clk_en=1.
  - instr_done → HALT.
  - STEP_TIMEOUT cycles without instr_done → HALT and sets step_timeout.
- HALT: cpu_rst=0, cpu_clk_en=0; CPU state is retained.
  - cmd_step → STEP.
  - cmd_run → RUN.
  - host_valid → LOAD, which re-asserts cpu_rst.
- Simultaneous commands: halt > step > run.
  - cmd_halt in HALT or IDLE is ignored.
  - cmd_step in RUN is ignored.
  - host_valid is accepted only in IDLE, HALT and LOAD.
- instr_count increments on instr_done when cpu_clk_en=1 and saturates at 255.
- load_err and step_timeout clear only on rst or on entry to LOAD.

## Timing
- All outputs are registered.
- Reset values: state IDLE, cpu_rst=1, cpu_clk_en=0, host_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, load_err=0, step_timeout=0, instr_count=0.
- Write latency: a handshake in cycle N produces mem_we=1 in cycle N+1. Throughput is one word per cycle.
- The host_valid that causes IDLE/HALT → LOAD is not accepted in that cycle, because host_ready is 0. It is accepted in the first LOAD cycle.
- Command latency: a command in cycle N gives the new state and new cpu_rst/cpu_clk_en in cycle N+1.
- instr_done in cycle N in STEP gives cpu_clk_en=0 in cycle N+1. The CPU sees exactly one completed instruction.
- Timeout counter:
  - Starts at 0 on STEP entry.
  - Fires when the counter reaches STEP_TIMEOUT−1 without instr_done.
  - If instr_done arrives in the same cycle, instr_done wins and no timeout is flagged.
- Asserting rst in any state returns all outputs to their reset values immediately. A partially loaded program is not invalidated by the controller.

## Structure
- Shared package holds the state encoding constants, the default ADDR_W/DATA_W/DEPTH, and the instr_count width.
- One natural sub-module, cpu_load_port: the host handshake capture, the range check and the mem_we/addr/data registers.
- The FSM, command priority, timeout counter and instruction counter stay in the top module.

## Test plan
- Reset, then host writes (0,0x009), (1,0x02A), (2,0x04B), then host_load_done → three mem_we pulses with matching addr/data one cycle after each beat; state returns to IDLE; cpu_rst=1.
- Host write to addr 20 with DEPTH=16 → no mem_we; load_err=1 persists through RUN; clears on the next LOAD entry.
- cmd_run, then instr_done every 5 cycles for 4 instructions → cpu_clk_en=1 throughout; instr_count=4.
- In RUN, cmd_halt two cycles before instr_done → state stays RUN until instr_done, then HALT next cycle; cpu_clk_en=0.
- From HALT, cmd_step with instr_done after 6 cycles → HALT, instr_count +1. Repeat cmd_step with no instr_done → HALT after STEP_TIMEOUT cycles; step_timeout=1.
- cmd_halt, cmd_step and cmd_run asserted together in RUN → halt_pending set, no STEP. Assert rst mid-LOAD → all outputs at reset values next sample.
